// File: rtl/dense_seq_pkg.sv
// Shared types, default widths and the ReLU saturation helper
// for the dense layer sequencer.
package dense_seq_pkg;

  localparam int N_DEF = 8;
  localparam int K_DEF = 26;
  localparam int J_DEF = 128;
  localparam int KW    = $clog2(K_DEF);
  localparam int JW    = $clog2(J_DEF);
  localparam int ACC_W = 2 * N_DEF + KW;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_MEM,
    S_ARM,
    S_START,
    S_MWAIT,
    S_ACC,
    S_STORE,
    S_OUTPUT
  } state_t;

  // Clamp a signed sum into the unsigned n-bit lane range.
  function automatic logic [63:0] relu_sat(
    input logic signed [63:0] acc,
    input int unsigned        n
  );
    logic signed [63:0] top;
    top = (64'sd1 <<< n) - 64'sd1;
    if (acc < 0)
      return '0;
    if (acc > top)
      return top;
    return acc;
  endfunction

endpackage

// File: rtl/dense_mac_acc.sv
// Signed accumulator for one output lane, with a ReLU-saturated
// N-bit view of the running sum.
module dense_mac_acc
  import dense_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = 2 * N_DEF + KW
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clr,
  input  logic           add,
  input  logic [2*N-1:0] product,
  output logic [N-1:0]   lane
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;

  assign ext = {{(ACC_W - 2 * N){product[2*N-1]}}, product};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (add)
      acc <= acc + ext;
  end

  assign lane = N'(relu_sat(64'(acc), N));

endmodule

// File: rtl/dense_layer_sequencer.sv
// Dense layer controller: time-shares one sequential multiplier
// over all k,j pairs and packs ReLU-saturated lanes.
module dense_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int IN_FEATURES  = K_DEF,
  parameter int OUT_FEATURES = J_DEF,
  parameter int TIMEOUT      = 2 * N + 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            frame_valid,
  output logic                            frame_ready,
  output logic [$clog2(IN_FEATURES)-1:0]  feat_addr,
  input  logic [N-1:0]                    feat_data,
  output logic [$clog2(IN_FEATURES)-1:0]  wgt_row,
  output logic [$clog2(OUT_FEATURES)-1:0] wgt_col,
  input  logic [N-1:0]                    wgt_data,
  output logic [N-1:0]                    mul_multiplicand,
  output logic [N-1:0]                    mul_multiplier,
  output logic                            mul_start,
  input  logic                            mul_ready,
  input  logic [2*N-1:0]                  mul_product,
  output logic [OUT_FEATURES*N-1:0]       out_vector,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            err_timeout
);

  localparam int KA = $clog2(IN_FEATURES);
  localparam int JA = $clog2(OUT_FEATURES);
  localparam int AW = 2 * N + KA;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [KA-1:0] K_LAST = KA'(IN_FEATURES - 1);
  localparam logic [JA-1:0] J_LAST = JA'(OUT_FEATURES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        nxt;
  logic [KA-1:0] k;
  logic [JA-1:0] j;
  logic [N-1:0]  opa;
  logic [N-1:0]  opb;
  logic [TW-1:0] timer;
  logic          err;
  logic          clr;
  logic          add;
  logic          hit;
  logic          waiting;
  logic [N-1:0]  lane;

  dense_mac_acc #(
    .N     (N),
    .ACC_W (AW)
  ) u_acc (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .add     (add),
    .product (mul_product),
    .lane    (lane)
  );

  assign waiting = (state == S_ARM) || (state == S_MWAIT);

  always_comb begin
    nxt = state;
    clr = 1'b0;
    add = 1'b0;
    hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (frame_valid) begin
          nxt = S_FETCH;
          clr = 1'b1;
        end
      end
      S_FETCH: nxt = S_MEM;
      S_MEM:   nxt = S_ARM;
      S_ARM: begin
        if (mul_ready) begin
          nxt = S_START;
        end else if (timer == T_LAST) begin
          nxt = S_IDLE;
          hit = 1'b1;
        end
      end
      S_START: nxt = S_MWAIT;
      // first MWAIT cycle still sees the pre-start ready level
      S_MWAIT: begin
        if (timer != '0 && mul_ready) begin
          nxt = S_ACC;
        end else if (timer == T_LAST) begin
          nxt = S_IDLE;
          hit = 1'b1;
        end
      end
      S_ACC: begin
        add = 1'b1;
        nxt = (k == K_LAST) ? S_STORE : S_FETCH;
      end
      S_STORE: begin
        clr = 1'b1;
        nxt = (j == J_LAST) ? S_OUTPUT : S_FETCH;
      end
      S_OUTPUT: begin
        if (out_ready)
          nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      k          <= '0;
      j          <= '0;
      opa        <= '0;
      opb        <= '0;
      timer      <= '0;
      err        <= 1'b0;
      out_vector <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        timer <= '0;
      else if (waiting)
        timer <= timer + 1'b1;
      if (hit)
        err <= 1'b1;
      if (state == S_IDLE && frame_valid) begin
        k <= '0;
        j <= '0;
      end
      if (state == S_MEM) begin
        opa <= feat_data;
        opb <= wgt_data;
      end
      if (state == S_ACC && k != K_LAST)
        k <= k + 1'b1;
      if (state == S_STORE) begin
        k <= '0;
        out_vector[j*N +: N] <= lane;
        if (j != J_LAST)
          j <= j + 1'b1;
      end
    end
  end

  assign frame_ready      = (state == S_IDLE);
  assign busy             = (state != S_IDLE);
  assign out_valid        = (state == S_OUTPUT);
  assign mul_start        = (state == S_START);
  assign feat_addr        = k;
  assign wgt_row          = k;
  assign wgt_col          = j;
  assign mul_multiplicand = opa;
  assign mul_multiplier   = opb;
  assign err_timeout      = err;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer with a behavioural
// sequential multiplier and synchronous feature/weight memories.
`timescale 1ns/1ps
module tb_dense_layer_sequencer;

  localparam int N  = 8;
  localparam int K  = 26;
  localparam int J  = 8;
  localparam int TO = 2 * N + 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           frame_valid = 1'b0;
  logic           frame_ready;
  logic [4:0]     feat_addr;
  logic [N-1:0]   feat_data;
  logic [4:0]     wgt_row;
  logic [2:0]     wgt_col;
  logic [N-1:0]   wgt_data;
  logic [N-1:0]   mul_multiplicand;
  logic [N-1:0]   mul_multiplier;
  logic           mul_start;
  logic           mul_ready;
  logic [2*N-1:0] mul_product;
  logic [J*N-1:0] out_vector;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           busy;
  logic           err_timeout;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;
  int valids   = 0;
  logic vprev  = 1'b0;
  bit stuck    = 1'b0;

  logic [7:0] fmem [K];
  logic [7:0] wmem [K][J];

  typedef struct {
    logic [7:0] f;
    logic [7:0] w;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [8];

  always #5 clock = ~clock;

  dense_layer_sequencer #(
    .N            (N),
    .IN_FEATURES  (K),
    .OUT_FEATURES (J),
    .TIMEOUT      (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .frame_valid      (frame_valid),
    .frame_ready      (frame_ready),
    .feat_addr        (feat_addr),
    .feat_data        (feat_data),
    .wgt_row          (wgt_row),
    .wgt_col          (wgt_col),
    .wgt_data         (wgt_data),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_start        (mul_start),
    .mul_ready        (mul_ready),
    .mul_product      (mul_product),
    .out_vector       (out_vector),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .err_timeout      (err_timeout)
  );

  always @(posedge clock) begin
    feat_data <= fmem[feat_addr];
    wgt_data  <= wmem[wgt_row][wgt_col];
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
    end else if (mul_start && mul_ready) begin
      mul_ready   <= 1'b0;
      mul_product <= 16'($signed(mul_multiplicand)) * 16'($signed(mul_multiplier));
    end else if (!mul_ready && !stuck) begin
      mul_ready <= 1'b1;
    end
  end

  always @(negedge clock) begin
    if (mul_start)
      starts <= starts + 1;
    if (out_valid && !vprev)
      valids <= valids + 1;
    vprev <= out_valid;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] f, input logic [7:0] w);
    for (int a = 0; a < K; a++) begin
      fmem[a] = f;
      for (int b = 0; b < J; b++)
        wmem[a][b] = w;
    end
  endtask

  task automatic start_frame();
    @(negedge clock);
    frame_valid = 1'b1;
    @(negedge clock);
    frame_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!mul_start && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(mul_start), 64'd1);
  endtask

  task automatic handshake();
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int v0;
    int bad;
    logic [63:0] hold;

    vt[0] = '{f: 8'h01, w: 8'h01, exp: 8'h1A};
    vt[1] = '{f: 8'hFF, w: 8'h01, exp: 8'h00};
    vt[2] = '{f: 8'h7F, w: 8'h7F, exp: 8'hFF};
    vt[3] = '{f: 8'h05, w: 8'h03, exp: 8'hFF};
    vt[4] = '{f: 8'h01, w: 8'h03, exp: 8'h4E};
    vt[5] = '{f: 8'hFE, w: 8'hFF, exp: 8'h34};
    vt[6] = '{f: 8'h80, w: 8'h01, exp: 8'h00};
    vt[7] = '{f: 8'h09, w: 8'h01, exp: 8'hEA};

    load(8'h01, 8'h01);
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(frame_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(mul_start), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_err", 64'(err_timeout), 64'd0);
    check("idle_vec", out_vector, 64'd0);

    start_frame();
    wait_start("mid_start_seen");
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_start", 64'(mul_start), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_ready", 64'(frame_ready), 64'd1);
    check("mid_rst_err", 64'(err_timeout), 64'd0);

    for (int i = 0; i < 8; i++) begin
      load(vt[i].f, vt[i].w);
      s0 = starts;
      v0 = valids;
      start_frame();
      wait_valid($sformatf("vec%0d_valid", i));
      check($sformatf("vec%0d_lanes", i), out_vector, {J{vt[i].exp}});
      check($sformatf("vec%0d_starts", i), 64'(starts - s0), 64'(K * J));
      handshake();
      check($sformatf("vec%0d_once", i), 64'(valids - v0), 64'd1);
      check($sformatf("vec%0d_idle", i), 64'(frame_ready), 64'd1);
    end

    for (int a = 0; a < K; a++) begin
      fmem[a] = 8'h01;
      for (int b = 0; b < J; b++)
        wmem[a][b] = 8'(b);
    end
    start_frame();
    wait_valid("pack_valid");
    check("pack_lanes", out_vector, 64'hB69C_8268_4E34_1A00);

    hold = out_vector;
    s0 = starts;
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (!out_valid || out_vector !== hold || frame_ready || mul_start)
        bad++;
    end
    check("hold_stable", 64'(bad), 64'd0);
    check("hold_nostart", 64'(starts - s0), 64'd0);
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("hold_release_ready", 64'(frame_ready), 64'd1);
    check("hold_release_busy", 64'(busy), 64'd0);

    load(8'h01, 8'h01);
    stuck = 1'b1;
    v0 = valids;
    start_frame();
    wait_start("to_start_seen");
    repeat (20) @(negedge clock);
    check("to_not_yet", 64'(err_timeout), 64'd0);
    @(negedge clock);
    check("to_err", 64'(err_timeout), 64'd1);
    check("to_idle", 64'(frame_ready), 64'd1);
    repeat (3) @(negedge clock);
    check("to_novalid", 64'(valids - v0), 64'd0);
    stuck = 1'b0;
    load(8'h01, 8'h03);
    start_frame();
    wait_valid("to_next_valid");
    check("to_next_lanes", out_vector, {J{8'h4E}});
    check("to_sticky", 64'(err_timeout), 64'd1);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
